// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared types, range defaults and classification helper
package temp_pkg;

  typedef logic signed [10:0] temp_t;

  localparam int TEMP_BAJO_DEF = 180;
  localparam int TEMP_ALTO_DEF = 259;

  typedef enum logic [1:0] {INACTIVO, ESPERA, SOLICITUD, ACTUALIZA} muestreo_estado_t;
  typedef enum logic [1:0] {DENTRO, BAJO_R, ALTO_R} lado_t;

  // Signed compare: negative readings always land below the window.
  function automatic lado_t clasificar(input temp_t t, input temp_t bajo, input temp_t alto);
    if (t < bajo)      return BAJO_R;
    else if (t > alto) return ALTO_R;
    else               return DENTRO;
  endfunction

endpackage

// File: rtl/contador_persistencia.sv
// rtl/contador_persistencia.sv - classifies each registered sample and tracks the
// consecutive out-of-range run (side-aware, saturating) that drives persistencia.
module contador_persistencia
  import temp_pkg::*;
#(
  parameter int N_PERSIST = 4,
  parameter int TEMP_BAJO = TEMP_BAJO_DEF,
  parameter int TEMP_ALTO = TEMP_ALTO_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_limpiar,
  input  logic        i_evaluar,
  input  logic [10:0] i_temp,
  output logic [3:0]  o_cuenta,
  output logic        o_persistencia
);

  lado_t       r_lado;
  logic [3:0]  r_cuenta;
  logic        r_pers;
  lado_t       w_lado;
  logic [3:0]  w_cuenta;

  always_comb begin
    w_lado   = clasificar(temp_t'(i_temp), temp_t'(TEMP_BAJO), temp_t'(TEMP_ALTO));
    w_cuenta = r_cuenta;
    if (w_lado == DENTRO)
      w_cuenta = 4'd0;
    else if (r_lado != DENTRO && r_lado != w_lado)
      w_cuenta = 4'd1;
    else if (r_cuenta != 4'hF)
      w_cuenta = r_cuenta + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_limpiar) begin
      r_lado   <= DENTRO;
      r_cuenta <= 4'd0;
      r_pers   <= 1'b0;
    end else if (i_evaluar) begin
      r_lado   <= w_lado;
      r_cuenta <= w_cuenta;
      r_pers   <= (w_cuenta >= 4'(N_PERSIST));
    end
  end

  assign o_cuenta       = r_cuenta;
  assign o_persistencia = r_pers;

endmodule

// File: rtl/control_muestreo.sv
// rtl/control_muestreo.sv - sensor sampling scheduler: tick pacing, req/ack with timeout,
// registered temperature; MUESTREO_PROMEDIO_EN selects two-sample averaging of readings.
module control_muestreo
  import temp_pkg::*;
#(
  parameter int DIV_MUESTREO = 1000,
  parameter int TIMEOUT_ACK  = 16,
  parameter int N_PERSIST    = 4,
  parameter int TEMP_BAJO    = TEMP_BAJO_DEF,
  parameter int TEMP_ALTO    = TEMP_ALTO_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        habilitar,
  output logic        sensor_req,
  input  logic        sensor_ack,
  input  logic [10:0] sensor_dato,
  output logic [10:0] temp_registrado,
  output logic        muestra_valida,
  output logic        persistencia,
  output logic        error_sensor,
  output logic [3:0]  cuenta_fuera
);

  localparam int TICK_W = $clog2(DIV_MUESTREO);
  localparam int TO_W   = $clog2(TIMEOUT_ACK) + 1;
  localparam logic [TICK_W-1:0] TICK_FIN = TICK_W'(DIV_MUESTREO - 1);
  localparam logic [TO_W-1:0]   TO_FIN   = TO_W'(TIMEOUT_ACK - 1);

  muestreo_estado_t  r_estado, w_siguiente;
  logic [TICK_W-1:0] r_tick;
  logic [TO_W-1:0]   r_to;
  logic              r_req, r_valida, r_error;
  temp_t             r_temp, w_nuevo;
  logic              w_aceptar, w_timeout, w_evaluar, w_limpiar;

  always_ff @(posedge clk) begin
    if (!rst_n) r_estado <= INACTIVO;
    else        r_estado <= w_siguiente;
  end

  always_comb begin
    w_siguiente = r_estado;
    w_aceptar   = 1'b0;
    w_timeout   = 1'b0;
    w_evaluar   = 1'b0;
    if (!habilitar) begin
      w_siguiente = INACTIVO;
    end else begin
      case (r_estado)
        INACTIVO:  w_siguiente = ESPERA;
        ESPERA:    if (r_tick == TICK_FIN) w_siguiente = SOLICITUD;
        SOLICITUD: begin
          if (sensor_ack) begin
            w_aceptar   = 1'b1;
            w_siguiente = ACTUALIZA;
          end else if (r_to == TO_FIN) begin
            w_timeout   = 1'b1;
            w_siguiente = ESPERA;
          end
        end
        ACTUALIZA: begin
          w_evaluar   = 1'b1;
          w_siguiente = ESPERA;
        end
        default:   w_siguiente = INACTIVO;
      endcase
    end
  end

  assign w_limpiar = (w_siguiente == INACTIVO);

`ifdef MUESTREO_PROMEDIO_EN
  logic              r_primera;
  logic signed [11:0] w_suma;

  // Bits [11:1] of the 12-bit sum are exactly the arithmetic shift right by one.
  assign w_suma  = {r_temp[10], r_temp} + {sensor_dato[10], sensor_dato};
  assign w_nuevo = r_primera ? temp_t'(sensor_dato) : temp_t'(w_suma[11:1]);

  always_ff @(posedge clk) begin
    if (!rst_n || w_limpiar) r_primera <= 1'b1;
    else if (w_aceptar)      r_primera <= 1'b0;
  end
`else
  assign w_nuevo = temp_t'(sensor_dato);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick   <= '0;
      r_to     <= '0;
      r_req    <= 1'b0;
      r_valida <= 1'b0;
      r_error  <= 1'b0;
      r_temp   <= '0;
    end else begin
      r_req    <= (w_siguiente == SOLICITUD);
      r_valida <= w_evaluar;
      r_tick   <= (r_estado == ESPERA && w_siguiente == ESPERA) ? r_tick + TICK_W'(1) : '0;
      r_to     <= (r_estado == SOLICITUD && w_siguiente == SOLICITUD) ? r_to + TO_W'(1) : '0;
      if (w_aceptar)
        r_temp <= w_nuevo;
      if (w_timeout)
        r_error <= 1'b1;
      else if (w_evaluar)
        r_error <= 1'b0;
    end
  end

  contador_persistencia #(
    .N_PERSIST (N_PERSIST),
    .TEMP_BAJO (TEMP_BAJO),
    .TEMP_ALTO (TEMP_ALTO)
  ) u_persistencia (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_limpiar      (w_limpiar),
    .i_evaluar      (w_evaluar),
    .i_temp         (r_temp),
    .o_cuenta       (cuenta_fuera),
    .o_persistencia (persistencia)
  );

  assign sensor_req      = r_req;
  assign temp_registrado = r_temp;
  assign muestra_valida  = r_valida;
  assign error_sensor    = r_error;

endmodule

// File: tb/tb_control_muestreo.sv
// tb/tb_control_muestreo.sv - directed scoreboard bench for control_muestreo
module tb_control_muestreo;

  localparam int DIV  = 8;
  localparam int TOUT = 4;
  localparam int NP   = 3;
  localparam int BAJO = 180;
  localparam int ALTO = 259;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        habilitar = 1'b0;
  logic        sensor_req;
  logic        sensor_ack = 1'b0;
  logic [10:0] sensor_dato = '0;
  logic [10:0] temp_registrado;
  logic        muestra_valida;
  logic        persistencia;
  logic        error_sensor;
  logic [3:0]  cuenta_fuera;

  always #5 clk = ~clk;

  control_muestreo #(
    .DIV_MUESTREO (DIV),
    .TIMEOUT_ACK  (TOUT),
    .N_PERSIST    (NP),
    .TEMP_BAJO    (BAJO),
    .TEMP_ALTO    (ALTO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .habilitar       (habilitar),
    .sensor_req      (sensor_req),
    .sensor_ack      (sensor_ack),
    .sensor_dato     (sensor_dato),
    .temp_registrado (temp_registrado),
    .muestra_valida  (muestra_valida),
    .persistencia    (persistencia),
    .error_sensor    (error_sensor),
    .cuenta_fuera    (cuenta_fuera)
  );

  typedef struct {
    int t;
    int c;
    int p;
  } esp_t;

  esp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  int m_cuenta  = 0;
  int m_lado    = 0;
  int m_prev    = 0;
  int m_pers    = 0;
  int m_primera = 1;

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int temp_obs();
    return int'($signed(temp_registrado));
  endfunction

  task automatic modelo(input int dato, output esp_t e);
    int lado;
`ifdef MUESTREO_PROMEDIO_EN
    e.t = (m_primera != 0) ? dato : ((m_prev + dato) >>> 1);
`else
    e.t = dato;
`endif
    lado = (e.t < BAJO) ? 1 : ((e.t > ALTO) ? 2 : 0);
    if (lado == 0)                           m_cuenta = 0;
    else if (m_lado != 0 && m_lado != lado)  m_cuenta = 1;
    else if (m_cuenta < 15)                  m_cuenta++;
    m_lado    = lado;
    m_prev    = e.t;
    m_primera = 0;
    m_pers    = (m_cuenta >= NP) ? 1 : 0;
    e.c       = m_cuenta;
    e.p       = m_pers;
  endtask

  task automatic modelo_inactivo();
    m_cuenta  = 0;
    m_lado    = 0;
    m_pers    = 0;
    m_primera = 1;
  endtask

  task automatic esperar_req(input int n_esp, input string tag);
    int n = 0;
    while (!sensor_req && n < 4 * DIV + 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, n, n_esp);
  endtask

  task automatic muestra(input int dato, input int n_esp);
    esp_t e, o;
    int   n;
    esperar_req(n_esp, "req_periodo");
    @(posedge clk); #1;
    sensor_ack  = 1'b1;
    sensor_dato = 11'(dato);
    modelo(dato, e);
    q.push_back(e);
    @(posedge clk); #1;
    sensor_ack = 1'b0;
    chk("req_baja_ack", int'(sensor_req), 0);
    chk("temp_lat", temp_obs(), e.t);
    n = 0;
    while (!muestra_valida && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valida_lat", n, 1);
    o = q.pop_front();
    chk("temp", temp_obs(), o.t);
    chk("cuenta", int'(cuenta_fuera), o.c);
    chk("persistencia", int'(persistencia), o.p);
    chk("error_limpio", int'(error_sensor), 0);
    @(posedge clk); #1;
    chk("valida_pulso", int'(muestra_valida), 0);
  endtask

  task automatic sin_ack();
    int n = 0;
    esperar_req(DIV - 1, "req_periodo_to");
    while (sensor_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_ciclos", n, TOUT);
    chk("timeout_error", int'(error_sensor), 1);
    chk("timeout_temp", temp_obs(), m_prev);
    chk("timeout_cuenta", int'(cuenta_fuera), m_cuenta);
    chk("timeout_pers", int'(persistencia), m_pers);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", int'(sensor_req), 0);
    chk("rst_temp", temp_obs(), 0);
    chk("rst_valida", int'(muestra_valida), 0);
    chk("rst_pers", int'(persistencia), 0);
    chk("rst_error", int'(error_sensor), 0);
    chk("rst_cuenta", int'(cuenta_fuera), 0);

    rst_n     = 1'b1;
    habilitar = 1'b1;
    muestra(200, DIV + 1);
`ifdef MUESTREO_PROMEDIO_EN
    muestra(-101, DIV - 1);
    chk("promedio_49", temp_obs(), 49);
`endif
    muestra(150, DIV - 1);
    muestra(150, DIV - 1);
    muestra(150, DIV - 1);
    muestra(220, DIV - 1);
    muestra(150, DIV - 1);
    muestra(150, DIV - 1);
    muestra(300, DIV - 1);

    sin_ack();
    muestra(220, DIV);
    muestra(150, DIV - 1);
    muestra(150, DIV - 1);
    sin_ack();

    esperar_req(DIV, "req_antes_deshab");
    habilitar   = 1'b0;
    sensor_ack  = 1'b1;
    sensor_dato = 11'(500);
    @(posedge clk); #1;
    modelo_inactivo();
    chk("deshab_req", int'(sensor_req), 0);
    chk("deshab_cuenta", int'(cuenta_fuera), 0);
    chk("deshab_pers", int'(persistencia), 0);
    chk("deshab_error", int'(error_sensor), 1);
    chk("deshab_temp", temp_obs(), m_prev);
    @(posedge clk); #1;
    chk("deshab_ack_ignorado", temp_obs(), m_prev);
    chk("deshab_valida", int'(muestra_valida), 0);

    sensor_ack = 1'b0;
    habilitar  = 1'b1;
    esperar_req(DIV + 1, "req_reactivar");
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_req", int'(sensor_req), 0);
    chk("rst_mid_temp", temp_obs(), 0);
    chk("rst_mid_error", int'(error_sensor), 0);
    chk("rst_mid_cuenta", int'(cuenta_fuera), 0);
    chk("rst_mid_pers", int'(persistencia), 0);
    chk("rst_mid_valida", int'(muestra_valida), 0);
    chk("scoreboard_vacio", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
